// File: rtl/mu_access_ctrl.sv
// mu_access_ctrl
// Memory access sequencer that sits directly in front of the memory unit
// in the multicycle MIPS datapath. It accepts byte-addressed read and write
// requests through a valid/ready handshake. It converts MIPS text and data
// addresses into memory word indices and drives the memory write enable,
// write data and address. Read data is captured into the instruction
// register (IR) or the memory data register (MDR). Misaligned requests,
// out-of-range requests and writes to the text region are answered with an
// error code and never touch the memory.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid_i       request valid
//   req_ready_o       ready; high only in IDLE
//   req_we_i          1 = write, 0 = read
//   req_dst_i         read destination: 0 = IR, 1 = MDR
//   req_addr_i        byte address
//   req_wdata_i       write data
//   rsp_valid_o       one-cycle completion pulse
//   rsp_err_o         00 ok, 01 misaligned, 10 out of range, 11 text write
//   ir_o, mdr_o       instruction / memory data registers
//   mem_we_o          memory write enable
//   mem_wd_o          memory write data
//   mem_addr_o        memory word index
//   mem_rd_i          memory read data
module mu_access_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE  = 32'h1001_0000,
  parameter int                    TEXT_WORDS = 64,
  parameter int                    DATA_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_dst_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_err_o,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic [DATA_WIDTH-1:0] mdr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    FAULT
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_RANGE     = 2'b10;
  localparam logic [1:0] ERR_TEXT_WR   = 2'b11;

  localparam logic [DATA_WIDTH-1:0] TEXT_BYTES = DATA_WIDTH'(4 * TEXT_WORDS);
  localparam logic [DATA_WIDTH-1:0] DATA_BYTES = DATA_WIDTH'(4 * DATA_WORDS);
  localparam logic [DATA_WIDTH-1:0] DATA_IDX0  = DATA_WIDTH'(TEXT_WORDS);

  state_t state, state_next;

  logic                  we_q;
  logic                  dst_q;
  logic [1:0]            err_q;

  logic [DATA_WIDTH-1:0] text_off;
  logic [DATA_WIDTH-1:0] data_off;
  logic [1:0]            dec_err;
  logic [DATA_WIDTH-1:0] dec_index;
  logic                  accept;

  // Offsets wrap on underflow, so one unsigned compare against the region
  // size checks both the lower and the upper bound.
  assign text_off = req_addr_i - TEXT_BASE;
  assign data_off = req_addr_i - DATA_BASE;
  assign accept   = req_valid_i && (state == IDLE);

  // Address decode. Alignment is checked first, then the text region, then
  // the data region.
  always_comb begin
    dec_err   = ERR_OK;
    dec_index = '0;
    if (req_addr_i[1:0] != 2'b00) begin
      dec_err = ERR_MISALIGN;
    end else if (text_off < TEXT_BYTES) begin
      dec_index = text_off >> 2;
      if (req_we_i) begin
        dec_err = ERR_TEXT_WR;
      end
    end else if (data_off < DATA_BYTES) begin
      dec_index = DATA_IDX0 + (data_off >> 2);
    end else begin
      dec_err = ERR_RANGE;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake/memory control outputs. Write enable and
  // response flags are decoded from the state, so an asynchronous reset
  // drops them immediately.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = ERR_OK;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_next = (dec_err != ERR_OK) ? FAULT : ISSUE;
        end
      end
      ISSUE: begin
        mem_we_o   = we_q;
        state_next = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_next  = IDLE;
      end
      FAULT: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and read-data capture. The memory address and write data
  // are only updated for requests that will actually reach the memory, so a
  // faulted request leaves the last values on the memory bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      dst_q      <= 1'b0;
      err_q      <= ERR_OK;
      mem_addr_o <= '0;
      mem_wd_o   <= '0;
      ir_o       <= '0;
      mdr_o      <= '0;
    end else begin
      if (accept) begin
        we_q  <= req_we_i;
        dst_q <= req_dst_i;
        err_q <= dec_err;
        if (dec_err == ERR_OK) begin
          mem_addr_o <= dec_index;
          mem_wd_o   <= req_wdata_i;
        end
      end
      if (state == CAPTURE) begin
        if (dst_q) begin
          mdr_o <= mem_rd_i;
        end else begin
          ir_o <= mem_rd_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mu_access_ctrl.sv
// tb_mu_access_ctrl
// Directed testbench for mu_access_ctrl. A small 128-word memory model sits
// behind the DUT. Every expected value below is a hand-computed constant.
module tb_mu_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic        req_dst_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [1:0]  rsp_err_o;
  logic [31:0] ir_o;
  logic [31:0] mdr_o;
  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rd_i;

  logic [31:0] mem [0:127];

  int tests;
  int failed;

  mu_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_dst_i   (req_dst_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .ir_o        (ir_o),
    .mdr_o       (mdr_o),
    .mem_we_o    (mem_we_o),
    .mem_wd_o    (mem_wd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_i    (mem_rd_i)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: asynchronous read, synchronous write
  assign mem_rd_i = mem[mem_addr_o[6:0]];

  always @(posedge clk) begin
    if (mem_we_o) begin
      mem[mem_addr_o[6:0]] <= mem_wd_o;
    end
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request at a falling edge and return 1 unit after the
  // accept edge, with req_valid_i dropped again
  task automatic applyStimulus(input logic we, input logic dst,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_req", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_dst_i   = dst;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    step();
    req_valid_i = 1'b0;
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst         = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_dst_i   = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'hA5A5_0000 + i;
    end
    mem[2] = 32'h2008_0005;

    // Reset values while reset is held
    #12;
    checkOutput("rst_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_rsp_err", {30'b0, rsp_err_o}, 32'd0);
    checkOutput("rst_ir", ir_o, 32'd0);
    checkOutput("rst_mdr", mdr_o, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mem_wd", mem_wd_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Text read into IR: word 2
    applyStimulus(1'b0, 1'b0, 32'h0040_0008, 32'h0);
    checkOutput("rd_issue_addr", mem_addr_o, 32'd2);
    checkOutput("rd_issue_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("rd_issue_ready", {31'b0, req_ready_o}, 32'd0);
    checkOutput("rd_issue_rsp", {31'b0, rsp_valid_o}, 32'd0);
    step();
    checkOutput("rd_cap_addr", mem_addr_o, 32'd2);
    checkOutput("rd_cap_rsp", {31'b0, rsp_valid_o}, 32'd0);
    step();
    checkOutput("rd_resp_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("rd_resp_err", {30'b0, rsp_err_o}, 32'd0);
    checkOutput("rd_ir", ir_o, 32'h2008_0005);
    checkOutput("rd_mdr", mdr_o, 32'd0);
    step();
    checkOutput("rd_idle_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rd_idle_ready", {31'b0, req_ready_o}, 32'd1);

    // Data write: word 1 of the data region is index 65
    applyStimulus(1'b1, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    checkOutput("wr_issue_we", {31'b0, mem_we_o}, 32'd1);
    checkOutput("wr_issue_addr", mem_addr_o, 32'd65);
    checkOutput("wr_issue_wd", mem_wd_o, 32'hDEAD_BEEF);
    checkOutput("wr_issue_rsp", {31'b0, rsp_valid_o}, 32'd0);
    step();
    checkOutput("wr_resp_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("wr_resp_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("wr_resp_err", {30'b0, rsp_err_o}, 32'd0);
    checkOutput("wr_ir_kept", ir_o, 32'h2008_0005);
    checkOutput("wr_mdr_kept", mdr_o, 32'd0);
    step();
    checkOutput("wr_idle_we", {31'b0, mem_we_o}, 32'd0);

    // MDR read-back of the written word
    applyStimulus(1'b0, 1'b1, 32'h1001_0004, 32'h0);
    checkOutput("rb_issue_addr", mem_addr_o, 32'd65);
    step();
    step();
    checkOutput("rb_resp_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("rb_mdr", mdr_o, 32'hDEAD_BEEF);
    checkOutput("rb_ir_kept", ir_o, 32'h2008_0005);
    step();

    // Misaligned read: fault one cycle after accept, bus holds index 65
    applyStimulus(1'b0, 1'b0, 32'h1001_0002, 32'h0);
    checkOutput("mis_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("mis_err", {30'b0, rsp_err_o}, 32'd1);
    checkOutput("mis_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("mis_addr_hold", mem_addr_o, 32'd65);
    step();
    checkOutput("mis_idle_valid", {31'b0, rsp_valid_o}, 32'd0);

    // First word past the data region
    applyStimulus(1'b0, 1'b0, 32'h1001_0100, 32'h0);
    checkOutput("oor_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("oor_err", {30'b0, rsp_err_o}, 32'd2);
    checkOutput("oor_we", {31'b0, mem_we_o}, 32'd0);
    step();

    // Write to the text region
    applyStimulus(1'b1, 1'b0, 32'h0040_0000, 32'h1234_5678);
    checkOutput("txw_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("txw_err", {30'b0, rsp_err_o}, 32'd3);
    checkOutput("txw_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("txw_wd_hold", mem_wd_o, 32'h0);
    checkOutput("txw_mem0", mem[0], 32'hA5A5_0000);
    checkOutput("txw_ir_kept", ir_o, 32'h2008_0005);
    checkOutput("txw_mdr_kept", mdr_o, 32'hDEAD_BEEF);
    step();

    // Last text word, into MDR
    applyStimulus(1'b0, 1'b1, 32'h0040_00FC, 32'h0);
    checkOutput("bt_addr", mem_addr_o, 32'd63);
    step();
    step();
    checkOutput("bt_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bt_mdr", mdr_o, 32'hA5A5_003F);
    step();

    // Last data word, into IR
    applyStimulus(1'b0, 1'b0, 32'h1001_00FC, 32'h0);
    checkOutput("bd_addr", mem_addr_o, 32'd127);
    step();
    step();
    checkOutput("bd_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bd_ir", ir_o, 32'hA5A5_007F);
    step();

    // First word past the text region
    applyStimulus(1'b0, 1'b0, 32'h0040_0100, 32'h0);
    checkOutput("bx_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bx_err", {30'b0, rsp_err_o}, 32'd2);
    step();

    // Reset asserted during CAPTURE of a read
    applyStimulus(1'b0, 1'b0, 32'h1001_0000, 32'h0);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rc_ir", ir_o, 32'd0);
    checkOutput("rc_mdr", mdr_o, 32'd0);
    checkOutput("rc_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rc_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rc_mem_addr", mem_addr_o, 32'd0);
    step();
    checkOutput("rc_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rc_ir_held", ir_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted during ISSUE of a write: write enable drops at once
    applyStimulus(1'b1, 1'b0, 32'h1001_0008, 32'hCAFE_F00D);
    checkOutput("ri_we_before", {31'b0, mem_we_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ri_we_after", {31'b0, mem_we_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("ri_mem_untouched", mem[66], 32'hA5A5_0042);

    // Normal read after reset release
    applyStimulus(1'b0, 1'b1, 32'h0040_0008, 32'h0);
    checkOutput("ar_addr", mem_addr_o, 32'd2);
    step();
    step();
    checkOutput("ar_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("ar_err", {30'b0, rsp_err_o}, 32'd0);
    checkOutput("ar_mdr", mdr_o, 32'h2008_0005);
    checkOutput("ar_ir", ir_o, 32'd0);
    step();

    // Back-to-back reads with req_valid_i held high
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_dst_i   = 1'b0;
    req_addr_i  = 32'h0040_0004;
    step();
    checkOutput("bb0_addr", mem_addr_o, 32'd1);
    checkOutput("bb0_ready_issue", {31'b0, req_ready_o}, 32'd0);
    req_dst_i  = 1'b1;
    req_addr_i = 32'h1001_0000;
    step();
    checkOutput("bb0_ready_cap", {31'b0, req_ready_o}, 32'd0);
    checkOutput("bb0_addr_cap", mem_addr_o, 32'd1);
    step();
    checkOutput("bb0_ready_resp", {31'b0, req_ready_o}, 32'd0);
    checkOutput("bb0_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bb0_ir", ir_o, 32'hA5A5_0001);
    checkOutput("bb0_mdr", mdr_o, 32'h2008_0005);
    step();
    checkOutput("bb0_ready_idle", {31'b0, req_ready_o}, 32'd1);
    step();
    checkOutput("bb1_addr", mem_addr_o, 32'd64);
    req_dst_i  = 1'b0;
    req_addr_i = 32'h0040_000C;
    step();
    step();
    checkOutput("bb1_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bb1_mdr", mdr_o, 32'hA5A5_0040);
    checkOutput("bb1_ir", ir_o, 32'hA5A5_0001);
    step();
    step();
    checkOutput("bb2_addr", mem_addr_o, 32'd3);
    req_valid_i = 1'b0;
    step();
    step();
    checkOutput("bb2_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("bb2_ir", ir_o, 32'hA5A5_0003);
    checkOutput("bb2_mdr", mdr_o, 32'hA5A5_0040);
    step();
    checkOutput("bb_end_ready", {31'b0, req_ready_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mu_access_ctrl.md
Name: mu_access_ctrl

Overview:
- Memory access sequencer placed directly upstream of the memory unit in the multicycle MIPS datapath.
- Accepts byte-addressed read/write requests from the control unit/datapath using a valid/ready handshake.
- Translates MIPS text/data addresses to the memory unit's word index, then drives the memory's write-enable, write-data and address inputs.
- Captures read data into the instruction register (IR) or memory data register (MDR); rejects misaligned, out-of-range and text-write requests with an error response and no memory access.

Parameters:
- DATA_WIDTH, 32, data/address width; matches the memory unit.
- TEXT_BASE, 32'h0040_0000, byte base address of the text region.
- DATA_BASE, 32'h1001_0000, byte base address of the data region.
- TEXT_WORDS, 64, number of words in the text region; occupies memory word indices 0..TEXT_WORDS-1.
- DATA_WORDS, 64, number of words in the data region; occupies word indices TEXT_WORDS..TEXT_WORDS+DATA_WORDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  ready; high only in IDLE.
- req_we_i  in  1  1 = write, 0 = read.
- req_dst_i  in  1  read destination: 0 = IR, 1 = MDR; ignored for writes.
- req_addr_i  in  DATA_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_err_o  out  2  error code, meaningful only with rsp_valid_o: 00 ok, 01 misaligned, 10 out of range, 11 text-region write.
- ir_o  out  DATA_WIDTH  instruction register.
- mdr_o  out  DATA_WIDTH  memory data register.
- mem_we_o  out  1  to memory write enable.
- mem_wd_o  out  DATA_WIDTH  to memory write data.
- mem_addr_o  out  DATA_WIDTH  to memory address; word index.
- mem_rd_i  in  DATA_WIDTH  from memory read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - ir_o, mdr_o, mem_addr_o, mem_wd_o, rsp_err_o = 0.
  - mem_we_o = 0, rsp_valid_o = 0, req_ready_o = 1.
  - Reset mid-operation aborts the transaction: no response, IR/MDR cleared, mem_we_o drops without waiting for a clock edge.
- FSM states: IDLE, ISSUE, CAPTURE, RESP, FAULT.
- IDLE:
  - req_ready_o = 1.
  - On the edge where req_valid_i & req_ready_o, latch we, dst, wdata and the decoded address/error.
  - Next state is FAULT if error != 00, else ISSUE.
- Decode priority:
  - addr[1:0] != 0 -> 01.
  - Else addr in [TEXT_BASE, TEXT_BASE+4*TEXT_WORDS): index = (addr-TEXT_BASE)>>2; if we=1 -> 11.
  - Else addr in [DATA_BASE, DATA_BASE+4*DATA_WORDS): index = TEXT_WORDS + ((addr-DATA_BASE)>>2).
  - Else -> 10.
  - Bounds are inclusive low, exclusive high; subtraction is unsigned in DATA_WIDTH bits.
- ISSUE:
  - mem_addr_o = index, mem_wd_o = wdata.
  - mem_we_o = we; high for exactly this one cycle.
  - Next state: write -> RESP; read -> CAPTURE.
- CAPTURE:
  - mem_addr_o holds the index; mem_we_o = 0.
  - At the exiting edge, mem_rd_i is loaded into IR (dst=0) or MDR (dst=1). The other register is unchanged.
  - Next state: RESP.
- RESP: rsp_valid_o = 1, rsp_err_o = 00 for one cycle; next state IDLE.
- FAULT:
  - rsp_valid_o = 1, rsp_err_o = latched code for one cycle; next state IDLE.
  - mem_we_o stays 0; IR and MDR are unchanged.
- Latency, counted from the accept edge T0:
  - rsp_valid_o is high in cycle T0+3 for a read, T0+2 for a write, T0+1 for a fault.
- Back-to-back operation: a new request may be accepted on the edge leaving RESP/FAULT only via IDLE. Maximum throughput is one read per 4 cycles.
- Request inputs are ignored outside IDLE; the requester holds them until accepted.
- Writes never modify IR or MDR.
- mem_addr_o and mem_wd_o hold their last values in IDLE/RESP/FAULT.

Test Plan:
- Reset, then read req_addr=32'h0040_0008, dst=0, memory word 2 = 32'h2008_0005 -> mem_addr_o=2 in ISSUE; ir_o=32'h2008_0005 and rsp_valid with err 00 at T0+3; mdr_o stays 0.
- Write req_addr=32'h1001_0004, wdata=32'hDEAD_BEEF -> mem_we_o high for exactly one cycle with mem_addr_o=65 and mem_wd_o=32'hDEAD_BEEF; rsp at T0+2, err 00. A following MDR read of the same address returns 32'hDEAD_BEEF.
- Error cases, each giving rsp_valid at T0+1 with mem_we_o never asserted:
  - req_addr=32'h1001_0002 -> err 01.
  - req_addr=32'h1001_0100 (first word past the data region) -> err 10.
  - Write to 32'h0040_0000 -> err 11.
- Boundary addresses: read 32'h0040_00FC -> index 63; read 32'h1001_00FC -> index 127; read 32'h0040_0100 -> err 10.
- Assert rst in CAPTURE of a read -> outputs reset immediately, no rsp_valid pulse, ir_o=0. The next request after release completes normally.
- Hold req_valid high continuously across reads to different addresses -> req_ready_o low during ISSUE..RESP; one accept every 4 cycles; IR and MDR each update only on their own reads.
